// File: rtl/bcd_display_scan_pkg.sv
// ============================================================================
// Module   : bcd_disp_pkg
// Purpose  : Shared segment codes, scan state type and width helper for the
//            multiplexed BCD display blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_disp_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    // Bits needed to hold values 0..n-1; never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_display_scan_if.sv
// ============================================================================
// Module   : bcd_display_scan_if
// Purpose  : Digit input and display drive bundle for bcd_display_scan.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_display_scan_if #(
    parameter int ND = 4
);
    logic [4*ND-1:0] DIGITS;
    logic [ND-1:0]   AN;
    logic [6:0]      SEG;
    logic            FRAME;

    modport master (output DIGITS, input AN, input SEG, input FRAME);
    modport slave  (input DIGITS, output AN, output SEG, output FRAME);
endinterface

`default_nettype wire

// File: rtl/bcd_to_7seg.sv
// ============================================================================
// Module   : bcd_to_7seg
// Purpose  : Combinational BCD to active-low 7-segment decode; codes 10-15
//            render as a dash.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  wire logic [3:0] i_bcd,
    output logic      [6:0] o_seg
);

    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/bcd_display_scan.sv
// ============================================================================
// Module   : bcd_display_scan
// Purpose  : Frame-snapshotted multiplexed common-anode 7-segment scanner with
//            inter-digit blanking. Optional leading-zero suppression is
//            enabled by defining BCD_SCAN_LZ_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int ND        = 4,
    parameter int PRESCALE  = 1000,
    parameter int BLANK_CYC = 2
)(
    input  wire logic         CLK,
    input  wire logic         RSTn,
    bcd_display_scan_if.slave disp
);

    localparam int PCNT_W = clog2(PRESCALE);
    localparam int BCNT_W = clog2(BLANK_CYC + 1);
    localparam int IDX_W  = clog2(ND);

    localparam logic [PCNT_W-1:0] c_pcnt_last = PCNT_W'(PRESCALE - 1);
    localparam logic [BCNT_W-1:0] c_bcnt_last = BCNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0]  c_idx_last  = IDX_W'(ND - 1);

    logic [PCNT_W-1:0] r_pcnt;
    logic [BCNT_W-1:0] r_bcnt;
    logic [IDX_W-1:0]  r_idx;
    logic [4*ND-1:0]   r_snap;
    state_t            r_state;
    logic [ND-1:0]     r_an;
    logic [6:0]        r_seg;
    logic              r_frame;

    logic              w_tick;
    state_t            w_state_nxt;
    logic [BCNT_W-1:0] w_bcnt_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [4*ND-1:0]   w_snap_nxt;
    logic              w_frame_nxt;
    logic [3:0]        w_digit;
    logic [6:0]        w_dec_seg;
    logic              w_suppress;
    logic [ND-1:0]     w_an_nxt;
    logic [6:0]        w_seg_nxt;

    assign w_tick = (r_pcnt == c_pcnt_last);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_pcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    // State register; display outputs are registered alongside the state
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= BLANK;
            r_bcnt  <= '0;
            r_idx   <= c_idx_last;
            r_snap  <= '0;
            r_an    <= '1;
            r_seg   <= SEG_OFF;
            r_frame <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_idx   <= w_idx_nxt;
            r_snap  <= w_snap_nxt;
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
            r_frame <= w_frame_nxt;
        end
    end

    // Next-state: TICK wins over the blank counter so the slot grid stays fixed
    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_idx_nxt   = r_idx;
        w_snap_nxt  = r_snap;
        w_frame_nxt = 1'b0;
        if (w_tick) begin
            w_state_nxt = BLANK;
            w_bcnt_nxt  = '0;
            if (r_idx == c_idx_last) begin
                w_idx_nxt   = '0;
                w_snap_nxt  = disp.DIGITS;
                w_frame_nxt = 1'b1;
            end else begin
                w_idx_nxt = r_idx + 1'b1;
            end
        end else if (r_state == BLANK) begin
            w_bcnt_nxt = r_bcnt + 1'b1;
            if (r_bcnt == c_bcnt_last) begin
                w_state_nxt = SHOW;
            end
        end
    end

    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < ND; i++) begin
            if (w_idx_nxt == IDX_W'(i)) begin
                w_digit = w_snap_nxt[4*i +: 4];
            end
        end
    end

    bcd_to_7seg u_dec (
        .i_bcd (w_digit),
        .o_seg (w_dec_seg)
    );

`ifdef BCD_SCAN_LZ_BLANK_EN
    // Blank digit i>=1 when it and every digit above it are zero
    always_comb begin
        logic all_zero;
        all_zero   = 1'b1;
        w_suppress = 1'b0;
        for (int i = ND - 1; i >= 1; i--) begin
            all_zero = all_zero & (w_snap_nxt[4*i +: 4] == 4'd0);
            if (w_idx_nxt == IDX_W'(i)) begin
                w_suppress = all_zero;
            end
        end
    end
`else
    assign w_suppress = 1'b0;
`endif

    // Output decode from the next state so outputs change with the state
    always_comb begin
        w_an_nxt  = '1;
        w_seg_nxt = SEG_OFF;
        if (w_state_nxt == SHOW) begin
            for (int i = 0; i < ND; i++) begin
                if (w_idx_nxt == IDX_W'(i)) begin
                    w_an_nxt[i] = 1'b0;
                end
            end
            w_seg_nxt = w_suppress ? SEG_OFF : w_dec_seg;
        end
    end

    assign disp.AN    = r_an;
    assign disp.SEG   = r_seg;
    assign disp.FRAME = r_frame;

    a_no_tick_in_blank : assert property (
        @(posedge CLK) disable iff (!RSTn) !((r_state == BLANK) && w_tick)
    );

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_scan.sv
// ============================================================================
// Module   : tb_bcd_display_scan
// Purpose  : Directed self-checking bench for bcd_display_scan (4-digit scan
//            plus a 6-digit instance for slot timing).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_display_scan;
    import bcd_disp_pkg::*;

    logic clk;
    logic rstn;
    logic rstn2;
    int   n_total = 0;
    int   n_bad   = 0;

    bcd_display_scan_if #(.ND(4)) bus  ();
    bcd_display_scan_if #(.ND(6)) bus2 ();

    bcd_display_scan #(.ND(4), .PRESCALE(4), .BLANK_CYC(1)) dut (
        .CLK  (clk),
        .RSTn (rstn),
        .disp (bus)
    );

    bcd_display_scan #(.ND(6), .PRESCALE(10), .BLANK_CYC(3)) dut2 (
        .CLK  (clk),
        .RSTn (rstn2),
        .disp (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] s, input int d);
        logic [3:0] v;
        logic [6:0] r;
        v = s[4*d +: 4];
        case (v)
            4'd0: r = 7'b1000000;
            4'd1: r = 7'b1111001;
            4'd2: r = 7'b0100100;
            4'd3: r = 7'b0110000;
            4'd4: r = 7'b0011001;
            4'd5: r = 7'b0010010;
            4'd6: r = 7'b0000010;
            4'd7: r = 7'b1111000;
            4'd8: r = 7'b0000000;
            4'd9: r = 7'b0010000;
            default: r = 7'b0111111;
        endcase
`ifdef BCD_SCAN_LZ_BLANK_EN
        if (d >= 1) begin
            logic allz;
            allz = 1'b1;
            for (int k = d; k < 4; k++) begin
                if (s[4*k +: 4] != 4'd0) allz = 1'b0;
            end
            if (allz) r = 7'b1111111;
        end
`endif
        return r;
    endfunction

    // Advance one edge and compare {FRAME, AN, SEG}
    task automatic step_chk(input string tag, input logic f, input logic [3:0] an,
                            input logic [6:0] seg);
        @(posedge clk);
        #1;
        chk(tag, 32'({bus.FRAME, bus.AN, bus.SEG}), 32'({f, an, seg}));
    endtask

    // One 16-cycle frame starting just after a FRAME edge; optional DIGITS change
    task automatic run_frame(input string tag, input logic [15:0] s, input int chg_at,
                             input logic [15:0] chg_val);
        logic [3:0] an_e;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                if (d * 4 + c == chg_at) bus.DIGITS = chg_val;
                if (c < 3) begin
                    an_e    = 4'hF;
                    an_e[d] = 1'b0;
                    step_chk(tag, 1'b0, an_e, exp_seg(s, d));
                end else begin
                    step_chk(tag, (d == 3), 4'hF, 7'h7F);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int run  [6];
        int lowc [6];

        rstn        = 1'b0;
        rstn2       = 1'b0;
        bus.DIGITS  = 16'h1234;
        bus2.DIGITS = 24'h987654;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_an", 32'(bus.AN), 32'hF);
        chk("reset_seg", 32'(bus.SEG), 32'h7F);
        chk("reset_frame", 32'(bus.FRAME), 32'h0);

        rstn = 1'b1;
        repeat (3) step_chk("first_slot", 1'b0, 4'b0111, exp_seg(16'h0000, 3));
        step_chk("first_frame", 1'b1, 4'hF, 7'h7F);

        run_frame("scan_1234", 16'h1234, 5, 16'h9999);
        run_frame("scan_9999", 16'h9999, 0, 16'h8765);
        run_frame("scan_8765", 16'h8765, 0, 16'h00A0);
        run_frame("illegal_00a0", 16'h00A0, 0, 16'h0050);
        run_frame("lz_0050", 16'h0050, -1, 16'h0000);

        // Async reset while digit 1 is lit
        repeat (3) step_chk("pre_rst", 1'b0, 4'b1110, exp_seg(16'h0050, 0));
        step_chk("pre_rst", 1'b0, 4'hF, 7'h7F);
        step_chk("pre_rst", 1'b0, 4'b1101, exp_seg(16'h0050, 1));
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_async", 32'({bus.FRAME, bus.AN, bus.SEG}), 32'({1'b0, 4'hF, 7'h7F}));
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold", 32'({bus.FRAME, bus.AN, bus.SEG}), 32'({1'b0, 4'hF, 7'h7F}));
        rstn = 1'b1;
        repeat (3) step_chk("post_rst_slot", 1'b0, 4'b0111, exp_seg(16'h0000, 3));
        step_chk("post_rst_frame", 1'b1, 4'hF, 7'h7F);
        run_frame("post_rst_0050", 16'h0050, -1, 16'h0000);

        // Six-digit instance: slot widths and one-hot anodes
        rstn2 = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus2.FRAME && n < 200);
        chk("sweep_frame_found", 32'(bus2.FRAME), 32'h1);
        for (int i = 0; i < 6; i++) begin
            run[i]  = 0;
            lowc[i] = 0;
        end
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            chk("sweep_onehot", 32'($countones(~bus2.AN) <= 1), 32'h1);
            for (int i = 0; i < 6; i++) begin
                if (!bus2.AN[i]) begin
                    run[i]++;
                    lowc[i]++;
                end else if (run[i] != 0) begin
                    chk("sweep_run", 32'(run[i]), 32'd7);
                    run[i] = 0;
                end
            end
            if (c == 60) chk("sweep_period", 32'(bus2.FRAME), 32'h1);
        end
        for (int i = 0; i < 6; i++) chk("sweep_lowcnt", 32'(lowc[i]), 32'd7);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
